// File: rtl/pipe_hold_ctrl_if.sv
// Handshake bundle between the hold controller and its requesters (EX, CLINT, RIB, ID).
// master drives the requests and observes hold/redirect; slave is the controller itself.
interface pipe_hold_ctrl_if;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_ex_i;
   logic        hold_flag_rib_i;
   logic        int_assert_i;
   logic [31:0] int_addr_i;
   logic        hold_flag_clint_i;
   logic        ex_is_load_i;
   logic [4:0]  ex_rd_waddr_i;
   logic [4:0]  id_rs1_raddr_i;
   logic        id_rs1_re_i;
   logic [4:0]  id_rs2_raddr_i;
   logic        id_rs2_re_i;
   logic [2:0]  hold_flag_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        bus_err_o;

   modport master (
      output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i, int_assert_i,
             int_addr_i, hold_flag_clint_i, ex_is_load_i, ex_rd_waddr_i,
             id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
      input  hold_flag_o, jump_flag_o, jump_addr_o, bus_err_o
   );

   modport slave (
      input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i, int_assert_i,
             int_addr_i, hold_flag_clint_i, ex_is_load_i, ex_rd_waddr_i,
             id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
      output hold_flag_o, jump_flag_o, jump_addr_o, bus_err_o
   );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/redirect sequencer: merges stall sources into one hold level, issues PC
// redirects with zero latency, counts post-redirect bubbles and watches for bus-wait timeouts.
module pipe_hold_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned BUS_TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             rst,
   pipe_hold_ctrl_if.slave  bus
);
   localparam logic [2:0] HOLD_NONE = 3'd0;
   localparam logic [2:0] HOLD_PC   = 3'd1;
   localparam logic [2:0] HOLD_ID   = 3'd3;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_LDUSE = 2'd2;

   localparam logic [1:0] FLUSH_LOAD  = 2'(FLUSH_CYCLES);
   localparam logic [7:0] TIMEOUT_M1  = 8'(BUS_TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  flush_cnt_q, flush_cnt_d;
   logic [7:0]  bus_cnt_q, bus_cnt_d;

   logic        redirect;
   logic        ld_use_raw;
   logic        ld_use_hit;
   logic [2:0]  hold;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        bus_err;

   always_comb begin
      redirect   = bus.int_assert_i | bus.jump_flag_i;
      ld_use_raw = bus.ex_is_load_i && (bus.ex_rd_waddr_i != 5'd0) &&
                   ((bus.id_rs1_re_i && (bus.id_rs1_raddr_i == bus.ex_rd_waddr_i)) ||
                    (bus.id_rs2_re_i && (bus.id_rs2_raddr_i == bus.ex_rd_waddr_i)));
      // The load has already moved on while in LDUSE, so a match now is stale.
      ld_use_hit = ld_use_raw && (state_q != ST_LDUSE);

      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      bus_cnt_d   = 8'd0;
      hold        = HOLD_NONE;
      jump_flag   = 1'b0;
      jump_addr   = 32'd0;
      bus_err     = 1'b0;

      if (bus.int_assert_i) begin
         jump_flag = 1'b1;
         jump_addr = bus.int_addr_i;
      end else if (bus.jump_flag_i) begin
         jump_flag = 1'b1;
         jump_addr = bus.jump_addr_i;
      end

      // Ordered lowest to highest so the strongest request wins.
      if (bus.hold_flag_rib_i)
         hold = HOLD_PC;
      if (redirect || bus.hold_flag_clint_i || bus.hold_flag_ex_i || ld_use_hit ||
          (state_q == ST_FLUSH))
         hold = HOLD_ID;

      if (bus.hold_flag_rib_i) begin
         if (bus_cnt_q == TIMEOUT_M1) begin
            bus_err   = 1'b1;
            bus_cnt_d = 8'd0;
         end else if (bus_cnt_q != 8'hff) begin
            bus_cnt_d = bus_cnt_q + 8'd1;
         end else begin
            bus_cnt_d = bus_cnt_q;
         end
      end

      if (redirect) begin
         flush_cnt_d = FLUSH_LOAD;
         state_d     = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
      end else begin
         case (state_q)
            ST_RUN:   if (ld_use_hit) state_d = ST_LDUSE;
            ST_FLUSH: begin
               flush_cnt_d = flush_cnt_q - 2'd1;
               if (flush_cnt_q <= 2'd1) begin
                  flush_cnt_d = 2'd0;
                  state_d     = ST_RUN;
               end
            end
            ST_LDUSE: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end

      if (rst) begin
         hold      = HOLD_NONE;
         jump_flag = 1'b0;
         jump_addr = 32'd0;
         bus_err   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= 2'd0;
         bus_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         bus_cnt_q   <= bus_cnt_d;
      end
   end

   assign bus.hold_flag_o = hold;
   assign bus.jump_flag_o = jump_flag;
   assign bus.jump_addr_o = jump_addr;
   assign bus.bus_err_o   = bus_err;
endmodule
